cic_comb_decimator: RTL and testbench

- Back end of the CIC decimation chain; consumes the wrapped running-sum stream from the cascaded integrator stages.
- Keeps every R-th valid input sample (rate reduction).
- Runs N pipelined comb (differentiator) stages with differential delay M on the kept samples and emits decimated filter output with a one-cycle valid strobe.

---
 rtl/cic_comb_decimator_pkg.sv | 22 ++
 rtl/cic_comb_decimator_comb_stage.sv | 42 ++++
 rtl/cic_comb_decimator.sv | 87 ++++++++
 tb/tb_cic_comb_decimator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comb_decimator_pkg.sv
// Shared CIC constants and counter-width helpers, common to the integrator and comb halves
// so widths and stage counts stay consistent across the chain.
package cic_defs;

    localparam int CIC_BITS = 10;
    localparam int CIC_R    = 8;
    localparam int CIC_N    = 3;
    localparam int CIC_M    = 1;

    // A ratio of 1 still needs a one-bit counter so the keep logic stays uniform.
    function automatic int dec_cnt_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic int out_cnt_w(input int nm);
        return $clog2(nm + 1);
    endfunction

    localparam int DEC_CNT_W = dec_cnt_w(CIC_R);
    localparam int OUT_CNT_W = out_cnt_w(CIC_N * CIC_M);

endpackage

// File: rtl/cic_comb_decimator_comb_stage.sv
// One CIC comb (differentiator) stage: y = x - x[n-M], modulo 2^BITS, registered output.
module cic_comb_stage #(
    parameter int BITS = 10,
    parameter int M    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] in,
    input  logic            in_valid,
    output logic [BITS-1:0] out,
    output logic            out_valid
);

    logic signed [BITS-1:0] taps [M];
    logic signed [BITS-1:0] diff;

    // Result kept at BITS wide: the borrow is dropped so integrator wrap cancels exactly.
    function automatic logic signed [BITS-1:0] wrap_sub(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        return a - b;
    endfunction

    assign diff = wrap_sub(signed'(in), taps[M-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) taps[i] <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                taps[0] <= signed'(in);
                for (int i = 1; i < M; i++) taps[i] <= taps[i-1];
                out <= unsigned'(diff);
            end
        end
    end

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th valid integrator sample and runs it through
// N pipelined comb stages; ready strobes each new output, primed marks the flushed transient.
module cic_comb_decimator
    import cic_defs::*;
#(
    parameter int BITS = CIC_BITS,
    parameter int R    = CIC_R,
    parameter int N    = CIC_N,
    parameter int M    = CIC_M
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] stream_in,
    input  logic            valid,
    output logic [BITS-1:0] stream_out,
    output logic            ready,
    output logic            primed
);

    localparam int            CW        = dec_cnt_w(R);
    localparam int            PW        = out_cnt_w(N * M);
    localparam logic [CW-1:0] CNT_LAST  = CW'(R - 1);
    localparam logic [PW-1:0] PRIME_CNT = PW'(N * M);

    logic [CW-1:0]          dec_cnt;
    logic                   keep;
    logic signed [BITS-1:0] data_p0;
    logic                   vld_p0;
    logic [BITS-1:0]        chain_data [N+1];
    logic [N:0]             chain_vld;
    logic [PW-1:0]          out_cnt;

    // Decimation: the counter only moves on valid cycles, so gaps are transparent.
    assign keep = valid && (dec_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (valid) begin
            dec_cnt <= (dec_cnt == CNT_LAST) ? '0 : dec_cnt + CW'(1);
        end
    end

    // Stage 0: register the kept sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= keep;
            if (keep) data_p0 <= signed'(stream_in);
        end
    end

    assign chain_data[0] = unsigned'(data_p0);
    assign chain_vld[0]  = vld_p0;

    // Stages 1..N: comb chain; each stage adds one cycle of latency.
    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .BITS (BITS),
            .M    (M)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (chain_data[k]),
            .in_valid  (chain_vld[k]),
            .out       (chain_data[k+1]),
            .out_valid (chain_vld[k+1])
        );
    end

    assign stream_out = chain_data[N];
    assign ready      = chain_vld[N];

    // Counting on the last stage's input valid lets primed rise together with that ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (chain_vld[N-1] && (out_cnt != PRIME_CNT)) begin
            out_cnt <= out_cnt + PW'(1);
        end
    end

    assign primed = (out_cnt == PRIME_CNT);

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Scoreboard bench for cic_comb_decimator across four parameter sets
// (A: R4/N1/M1, B: R1/N1/M1, C: R1/N3/M1, D: R1/N1/M2).
module tb_cic_comb_decimator;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [W-1:0] din  [4];
    logic [3:0]   dval;
    logic [W-1:0] dout [4];
    logic [3:0]   drdy;
    logic [3:0]   dprm;

    cic_comb_decimator #(.BITS(W), .R(4), .N(1), .M(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .stream_in(din[0]), .valid(dval[0]),
        .stream_out(dout[0]), .ready(drdy[0]), .primed(dprm[0]));
    cic_comb_decimator #(.BITS(W), .R(1), .N(1), .M(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .stream_in(din[1]), .valid(dval[1]),
        .stream_out(dout[1]), .ready(drdy[1]), .primed(dprm[1]));
    cic_comb_decimator #(.BITS(W), .R(1), .N(3), .M(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .stream_in(din[2]), .valid(dval[2]),
        .stream_out(dout[2]), .ready(drdy[2]), .primed(dprm[2]));
    cic_comb_decimator #(.BITS(W), .R(1), .N(1), .M(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .stream_in(din[3]), .valid(dval[3]),
        .stream_out(dout[3]), .ready(drdy[3]), .primed(dprm[3]));

    typedef struct {
        logic [W-1:0] data;
        logic         primed;
        int           due;
    } exp_t;

    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dval  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        dval[0] = 1'b1;
        din[0]  = W'(77);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if (dout[0] !== '0 || drdy[0] !== 1'b0 || dprm[0] !== 1'b0)
                $display("FAIL reset_hold: out=%0d ready=%b primed=%b, want 0/0/0", dout[0], drdy[0], dprm[0]);
            else n_pass++;
        end
        rst_n = 1'b1;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_total++;
                if (drdy[0] !== 1'b1 || dout[0] !== W'(77) || dprm[0] !== 1'b1)
                    $display("FAIL reset_first_out: out=%0d ready=%b primed=%b, want 77/1/1", dout[0], drdy[0], dprm[0]);
                else n_pass++;
            end
            din[0] = (c == 4) ? W'(55) : W'(1);
        end
        @(posedge clk);
        #2;
        dval[0] = 1'b0;
        rst_n   = 1'b0;
        #1;
        n_total++;
        if (dout[0] !== '0 || drdy[0] !== 1'b0 || dprm[0] !== 1'b0)
            $display("FAIL reset_async: out=%0d ready=%b primed=%b, want 0/0/0", dout[0], drdy[0], dprm[0]);
        else n_pass++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 3) rst_n = 1'b1;
            n_total++;
            if (drdy[0] !== 1'b0 || dout[0] !== '0)
                $display("FAIL reset_no_pending: ready=%b out=%0d, want 0/0", drdy[0], dout[0]);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        exp_t e;
        logic [W-1:0] last = '0;
        logic cur_p = 1'b0;
        sb.delete();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_total++;
            if (drdy[0]) begin
                if (sb.size() == 0) $display("FAIL ramp_extra: out=%0d at cycle %0d, want no output", dout[0], c);
                else begin
                    e = sb.pop_front();
                    if (dout[0] !== e.data || dprm[0] !== e.primed || c != e.due)
                        $display("FAIL ramp_out: out=%0d primed=%b cycle=%0d, want %0d/%b/%0d", dout[0], dprm[0], c, e.data, e.primed, e.due);
                    else n_pass++;
                    last = e.data; cur_p = e.primed;
                end
            end else if (dout[0] !== last || dprm[0] !== cur_p || (sb.size() > 0 && sb[0].due <= c))
                $display("FAIL ramp_idle: out=%0d primed=%b cycle=%0d, want hold %0d/%b", dout[0], dprm[0], c, last, cur_p);
            else n_pass++;
            if (c < 16) begin
                dval[0] = 1'b1;
                din[0]  = W'(c + 1);
                if (c % 4 == 0) begin
                    e.data = (c == 0) ? W'(1) : W'(4); e.primed = 1'b1; e.due = c + 2;
                    sb.push_back(e);
                end
            end else dval[0] = 1'b0;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL ramp_drain: %0d outputs missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_gapped();
        exp_t e;
        logic [7:0] pat = 8'b11011001;
        logic [W-1:0] last = '0;
        pulse_reset();
        sb.delete();
        e.data = W'(100); e.primed = 1'b1; e.due = 2; sb.push_back(e);
        e.data = W'(7);   e.primed = 1'b1; e.due = 9; sb.push_back(e);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_total++;
            if (drdy[0]) begin
                if (sb.size() == 0) $display("FAIL gap_extra: out=%0d at cycle %0d, want no output", dout[0], c);
                else begin
                    e = sb.pop_front();
                    if (dout[0] !== e.data || dprm[0] !== e.primed || c != e.due)
                        $display("FAIL gap_out: out=%0d primed=%b cycle=%0d, want %0d/%b/%0d", dout[0], dprm[0], c, e.data, e.primed, e.due);
                    else n_pass++;
                    last = e.data;
                end
            end else if (dout[0] !== last || (sb.size() > 0 && sb[0].due <= c))
                $display("FAIL gap_idle: out=%0d cycle=%0d, want hold %0d", dout[0], c, last);
            else n_pass++;
            dval[0] = (c < 8) ? pat[c] : 1'b0;
            din[0]  = W'(100 + c);
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL gap_drain: %0d outputs missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [W-1:0] last = '0;
        sb.delete();
        e.data = W'(1020); e.primed = 1'b1; e.due = 2; sb.push_back(e);
        e.data = W'(6);    e.primed = 1'b1; e.due = 3; sb.push_back(e);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_total++;
            if (drdy[1]) begin
                if (sb.size() == 0) $display("FAIL wrap_extra: out=%0d at cycle %0d, want no output", dout[1], c);
                else begin
                    e = sb.pop_front();
                    if (dout[1] !== e.data || dprm[1] !== e.primed || c != e.due)
                        $display("FAIL wrap_out: out=%0d primed=%b cycle=%0d, want %0d/%b/%0d", dout[1], dprm[1], c, e.data, e.primed, e.due);
                    else n_pass++;
                    last = e.data;
                end
            end else if (dout[1] !== last || (sb.size() > 0 && sb[0].due <= c))
                $display("FAIL wrap_idle: out=%0d cycle=%0d, want hold %0d", dout[1], c, last);
            else n_pass++;
            dval[1] = (c < 2);
            din[1]  = (c == 0) ? W'(1020) : W'(2);
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL wrap_drain: %0d outputs missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_impulse();
        exp_t e;
        int imp [8] = '{1, 1021, 3, 1023, 0, 0, 0, 0};
        sb.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_total++;
            if (drdy[2]) begin
                if (sb.size() == 0) $display("FAIL imp_extra: out=%0d at cycle %0d, want no output", dout[2], c);
                else begin
                    e = sb.pop_front();
                    if (dout[2] !== e.data || dprm[2] !== e.primed || c != e.due)
                        $display("FAIL imp_out: out=%0d primed=%b cycle=%0d, want %0d/%b/%0d", dout[2], dprm[2], c, e.data, e.primed, e.due);
                    else n_pass++;
                end
            end else if (sb.size() > 0 && sb[0].due <= c)
                $display("FAIL imp_late: no output at cycle %0d, want %0d", c, sb[0].data);
            else n_pass++;
            if (c < 8) begin
                dval[2] = 1'b1;
                din[2]  = (c == 0) ? W'(1) : W'(0);
                e.data = W'(imp[c]); e.primed = (c >= 2); e.due = c + 4;
                sb.push_back(e);
            end else dval[2] = 1'b0;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL imp_drain: %0d outputs missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_delay_m2();
        exp_t e;
        int cst [4] = '{9, 9, 0, 0};
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++;
            if (drdy[3]) begin
                if (sb.size() == 0) $display("FAIL m2_extra: out=%0d at cycle %0d, want no output", dout[3], c);
                else begin
                    e = sb.pop_front();
                    if (dout[3] !== e.data || dprm[3] !== e.primed || c != e.due)
                        $display("FAIL m2_out: out=%0d primed=%b cycle=%0d, want %0d/%b/%0d", dout[3], dprm[3], c, e.data, e.primed, e.due);
                    else n_pass++;
                end
            end else if (sb.size() > 0 && sb[0].due <= c)
                $display("FAIL m2_late: no output at cycle %0d, want %0d", c, sb[0].data);
            else n_pass++;
            if (c < 4) begin
                dval[3] = 1'b1;
                din[3]  = W'(9);
                e.data = W'(cst[c]); e.primed = (c >= 1); e.due = c + 2;
                sb.push_back(e);
            end else dval[3] = 1'b0;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL m2_drain: %0d outputs missing, want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        dval  = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        test_reset();
        test_ramp();
        test_gapped();
        test_wrap();
        test_impulse();
        test_delay_m2();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
